lfsr_seq_ctrl: RTL and testbench

- Sequencer that drives the shared `shifter` register used by the LFSR datapath.
- Seeds the register, then steps it a programmed number of times, or continuously, at a prescaled rate. The register value stays on the 7-segment display long enough to read between steps.
- Computes the LFSR feedback itself, using taps 4,3,2,0, from the register readback.
- Exposes a start/busy/done/abort handshake to the requester.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_presc.sv | 28 ++
 rtl/lfsr_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: shifter opcodes, FSM states, feedback taps.
package lfsr_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_STEP = 3'b101;

  // Taps 4,3,2,0 of the low five register bits
  localparam logic [4:0] TAP_MASK = 5'b11101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic lfsr_fb(input logic [4:0] low_bits);
    return ^(low_bits & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr_presc.sv
// Step-rate prescaler: tick is high on the last of every PRESC cycles; clr restarts the count.
module lfsr_presc #(
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Seeds the shared shifter and steps it as an LFSR at a prescaled rate, with start/busy/done/abort.
// Define LFSR_ZERO_GUARD_EN to reload SEED_DEFAULT instead of stepping an all-zero register.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    CNT_WIDTH    = 16,
  parameter int                    PRESC        = 4,
  parameter logic [DATA_WIDTH-1:0] SEED_DEFAULT = 'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  steps,
  input  logic                  free_run,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] set,
  output logic                  busy,
  output logic                  done
);

`ifdef LFSR_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic [CNT_WIDTH-1:0]  remaining_reg;
  logic                  free_reg;
  logic                  tick;
  logic                  fb;
  logic                  reg_zero;
  logic                  presc_clr;

  assign fb        = lfsr_fb(reg_data[4:0]);
  assign reg_zero  = (reg_data == '0);
  // Holding the prescaler clear outside RUN makes every run start its count from zero
  assign presc_clr = (state_reg != RUN);

  lfsr_presc #(
    .PRESC(PRESC)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_reg      <= '0;
      remaining_reg <= '0;
      free_reg      <= 1'b0;
    end else begin
      if (state_reg == IDLE && start && !abort) begin
        seed_reg      <= seed;
        remaining_reg <= steps;
        free_reg      <= free_run;
      end else if (state_reg == RUN && tick && !abort && !free_reg
                   && remaining_reg != '0) begin
        remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (remaining_reg == '0 && !free_reg) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick && !free_reg && remaining_reg == CNT_WIDTH'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    op   = OP_HOLD;
    set  = '0;
    done = 1'b0;
    busy = (state_reg != IDLE);
    case (state_reg)
      LOAD: begin
        if (!abort) begin
          op  = OP_LOAD;
          set = seed_reg;
        end
      end
      RUN: begin
        if (tick && !abort) begin
          if (ZERO_GUARD && reg_zero) begin
            op  = OP_LOAD;
            set = SEED_DEFAULT;
          end else begin
            op  = OP_STEP;
            set = {{(DATA_WIDTH-1){1'b0}}, fb};
          end
        end
      end
      DONE: begin
        done = !abort;
      end
      default: begin
        op = OP_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench: two sequencers (PRESC=1 and PRESC=4) share stimulus, each drives its own shifter model.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

`ifdef LFSR_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  seed = '0;
  logic [15:0] steps = '0;
  logic        free_run = 1'b0;
  logic        abort = 1'b0;

  logic [7:0] reg1 = '0, reg4 = '0;
  logic [2:0] op1, op4;
  logic [7:0] set1, set4;
  logic       busy1, busy4, done1, done4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] fin1, fin4;

  typedef struct {
    int         cyc;
    logic [2:0] op;
    logic [7:0] set;
    bit         done;
  } ev_t;

  ev_t q1[$];
  ev_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_seq_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16), .PRESC(1), .SEED_DEFAULT(8'h01)) u_p1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .steps(steps), .free_run(free_run),
    .abort(abort), .reg_data(reg1), .op(op1), .set(set1), .busy(busy1), .done(done1));

  lfsr_seq_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16), .PRESC(4), .SEED_DEFAULT(8'h01)) u_p4 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .steps(steps), .free_run(free_run),
    .abort(abort), .reg_data(reg4), .op(op4), .set(set4), .busy(busy4), .done(done4));

  // Shifter models, never cleared by rst
  always @(posedge clk) begin
    case (op1)
      OP_LOAD: reg1 <= set1;
      OP_STEP: reg1 <= {set1[0], reg1[7:1]};
      default: ;
    endcase
    case (op4)
      OP_LOAD: reg4 <= set4;
      OP_STEP: reg4 <= {set4[0], reg4[7:1]};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected shifter events for one run; k is the LOAD cycle, ab the abort offset from k (0 = none)
  task automatic push_run(input int p, input int k, input logic [7:0] sd, input int n,
                          input bit fr, input int ab, output logic [7:0] fin);
    ev_t e;
    logic [7:0] r;
    logic fb;
    r = sd;
    e.cyc = k; e.op = OP_LOAD; e.set = sd; e.done = 1'b0;
    if (p == 1) q1.push_back(e); else q4.push_back(e);
    for (int i = 1; (fr || i <= n) && (ab == 0 || i * p < ab); i++) begin
      e.cyc = k + i * p;
      e.done = 1'b0;
      if (GUARD && r == 8'h00) begin
        e.op = OP_LOAD; e.set = 8'h01; r = 8'h01;
      end else begin
        fb = r[4] ^ r[3] ^ r[2] ^ r[0];
        e.op = OP_STEP; e.set = {7'b0, fb}; r = {fb, r[7:1]};
      end
      if (p == 1) q1.push_back(e); else q4.push_back(e);
    end
    if (!fr && (ab == 0 || 1 + n * p < ab)) begin
      e.cyc = k + 1 + n * p; e.op = OP_HOLD; e.set = 8'h00; e.done = 1'b1;
      if (p == 1) q1.push_back(e); else q4.push_back(e);
    end
    fin = r;
  endtask

  task automatic mon(input int p, input logic [2:0] op, input logic [7:0] st,
                     input logic dn, input logic bz);
    ev_t e;
    string nm;
    nm = (p == 1) ? "p1" : "p4";
    if (op != OP_HOLD || dn) begin
      if ((p == 1) ? (q1.size() == 0) : (q4.size() == 0)) begin
        chk({nm, "_spurious"}, {28'd0, dn, op}, 32'd0);
      end else begin
        e = (p == 1) ? q1.pop_front() : q4.pop_front();
        chk({nm, "_cyc"}, cyc, e.cyc);
        chk({nm, "_op"}, {29'd0, op}, {29'd0, e.op});
        chk({nm, "_set"}, {24'd0, st}, {24'd0, e.set});
        chk({nm, "_done"}, {31'd0, dn}, {31'd0, e.done});
        chk({nm, "_busy"}, {31'd0, bz}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1, op1, set1, done1, busy1);
      mon(4, op4, set4, done4, busy4);
    end
  end

  task automatic go(input logic [7:0] sd, input int n, input bit fr, input int ab, output int k);
    @(posedge clk); #1;
    k = cyc + 1;
    push_run(1, k, sd, n, fr, ab, fin1);
    push_run(4, k, sd, n, fr, ab, fin4);
    start = 1'b1; seed = sd; steps = n[15:0]; free_run = fr;
    @(posedge clk); #1;
    start = 1'b0; seed = 8'($urandom); steps = 16'($urandom); free_run = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || busy4) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'd0, n < 300}, 32'd1);
  endtask

  task automatic end_run(input string tag);
    chk({tag, "_p1_q"}, q1.size(), 32'd0);
    chk({tag, "_p4_q"}, q4.size(), 32'd0);
    chk({tag, "_p1_reg"}, {24'd0, reg1}, {24'd0, fin1});
    chk({tag, "_p4_reg"}, {24'd0, reg4}, {24'd0, fin4});
    q1.delete();
    q4.delete();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op", {29'd0, op1}, {29'd0, OP_HOLD});
    chk("rst_set", {24'd0, set1}, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("rst_done", {30'd0, done1, done4}, 32'd0);
    @(negedge clk) rst = 1'b0;

    go(8'h01, 5, 1'b0, 0, k); wait_idle(); end_run("seq5");
    $display("run seed=01 steps=5 p1_reg=%h p4_reg=%h", reg1, reg4);
    go(8'h01, 2, 1'b0, 0, k); wait_idle(); end_run("presc2");
    $display("run seed=01 steps=2 p1_reg=%h p4_reg=%h", reg1, reg4);
    go(8'hA5, 0, 1'b0, 0, k); wait_idle(); end_run("zero_steps");
    $display("run seed=a5 steps=0 p1_reg=%h p4_reg=%h", reg1, reg4);

    // Free run aborted on the third PRESC=4 tick
    go(8'h5A, 0, 1'b1, 12, k);
    repeat (12) @(posedge clk);
    #1 abort = 1'b1;
    #1;
    chk("abort_op1", {29'd0, op1}, {29'd0, OP_HOLD});
    chk("abort_op4", {29'd0, op4}, {29'd0, OP_HOLD});
    chk("abort_busy", {30'd0, busy1, busy4}, 32'd3);
    chk("abort_done", {30'd0, done1, done4}, 32'd0);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", {30'd0, busy1, busy4}, 32'd0);
    repeat (4) @(posedge clk);
    #1 end_run("abort");
    $display("run free seed=5a abort p1_reg=%h p4_reg=%h", reg1, reg4);

    // Second start while busy must be ignored
    go(8'h3C, 3, 1'b0, 0, k);
    start = 1'b1; seed = 8'hFF; steps = 16'd9;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(); end_run("busy_start");
    $display("run seed=3c steps=3 busy-start p1_reg=%h p4_reg=%h", reg1, reg4);

    @(posedge clk); #1 start = 1'b1; abort = 1'b1; seed = 8'h77; steps = 16'd4; free_run = 1'b0;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {30'd0, busy1, busy4}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("start_abort_idle", {30'd0, busy1, busy4}, 32'd0);
    $display("start+abort in idle busy=%b%b", busy1, busy4);

    go(8'h00, 2, 1'b0, 0, k); wait_idle(); end_run("zero_seed");
    $display("run seed=00 steps=2 guard=%0d p1_reg=%h p4_reg=%h", GUARD, reg1, reg4);

    // Asynchronous reset mid-run
    go(8'h01, 20, 1'b0, 0, k);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    q1.delete();
    q4.delete();
    chk("arst_op", {26'd0, op1, op4}, 32'd0);
    chk("arst_set", {16'd0, set1, set4}, 32'd0);
    chk("arst_busy", {30'd0, busy1, busy4}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_p1_reg", {24'd0, reg1}, 32'h40);
    chk("arst_p4_reg", {24'd0, reg4}, 32'h01);
    @(negedge clk) rst = 1'b0;
    $display("async reset mid-run p1_reg=%h p4_reg=%h", reg1, reg4);

    go(8'h81, 1, 1'b0, 0, k); wait_idle(); end_run("recover");
    $display("run seed=81 steps=1 p1_reg=%h p4_reg=%h", reg1, reg4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
